// File: rtl/fxp_seq_neuron.sv
`default_nettype none
// ============================================================================
//  Module   : fxp_seq_neuron
//  Purpose  : Sequential fixed-point neuron with in-place backprop training.
//             A single MAC is time-shared: N_INPUTS cycles for the forward
//             sum, N_OUTPUTS cycles for the downstream gradient sum, then
//             N_INPUTS+1 cycles of weight/bias update.
//  Ports    : clk, rst (synchronous, active-high)
//             in_valid/in_ready     request handshake (in_ready only in IDLE)
//             in_values             flattened inputs, element i at [i*DATA_W +: DATA_W]
//             activation            0 linear, 1 ReLU, 2 hard-sigmoid, 3 hard-tanh
//             train, lr_shift       enable update, learning rate 2^-lr_shift
//             next_weights/grads    next-layer weights and gradients of this unit
//             out_valid/out_ready   result handshake
//             prediction            activated output (Q format)
//             error_gradient        local delta (0 for inference)
//             weights_out           {bias, w[N_INPUTS-1], ..., w[0]}
//  Options  : FXP_NEURON_LFSR_INIT_EN - reset weights/bias from a 16-bit
//             Galois LFSR seeded with SEED; otherwise they reset to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module fxp_seq_neuron #(
    parameter int          N_INPUTS  = 4,
    parameter int          N_OUTPUTS = 2,
    parameter int          DATA_W    = 16,
    parameter int          FRAC_W    = 8,
    parameter int          ACC_W     = 40,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N_INPUTS*DATA_W-1:0]      in_values,
    input  logic [1:0]                      activation,
    input  logic                            train,
    input  logic [3:0]                      lr_shift,
    input  logic [N_OUTPUTS*DATA_W-1:0]     next_weights,
    input  logic [N_OUTPUTS*DATA_W-1:0]     next_grads,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               prediction,
    output logic [DATA_W-1:0]               error_gradient,
    output logic [(N_INPUTS+1)*DATA_W-1:0]  weights_out
);

    localparam int c_WIDE = ACC_W + DATA_W;   // headroom for saturating arithmetic
    localparam int c_PW   = 2 * DATA_W;       // full product width
    localparam int c_AW   = DATA_W + 2;       // activation working width
    localparam int c_MAXN = (N_INPUTS > N_OUTPUTS) ? N_INPUTS : N_OUTPUTS;
    localparam int c_CW   = $clog2(c_MAXN + 1);

    localparam logic signed [c_WIDE-1:0] c_SMAX   = c_WIDE'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [c_WIDE-1:0] c_SMIN   = -c_SMAX - c_WIDE'(1);
    localparam logic signed [DATA_W-1:0] c_ONE    = DATA_W'(1 << FRAC_W);
    localparam logic signed [DATA_W-1:0] c_QUART  = DATA_W'(1 << (FRAC_W - 2));
    localparam logic signed [c_AW-1:0]   c_ONE_A  = c_AW'(1 << FRAC_W);
    localparam logic signed [c_AW-1:0]   c_HALF_A = c_AW'(1 << (FRAC_W - 1));
    localparam logic signed [c_AW-1:0]   c_TWO_A  = c_AW'(2 << FRAC_W);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MAC    = 3'd1,
        S_ACT    = 3'd2,
        S_GRAD   = 3'd3,
        S_UPDATE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [c_WIDE-1:0] v);
        if (v > c_SMAX)      return c_SMAX[DATA_W-1:0];
        else if (v < c_SMIN) return c_SMIN[DATA_W-1:0];
        else                 return v[DATA_W-1:0];
    endfunction

`ifdef FXP_NEURON_LFSR_INIT_EN
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        // Galois form, taps 16,14,13,11
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Signed low FRAC_W bits of the state reached after n steps from SEED
    function automatic logic signed [DATA_W-1:0] lfsr_word(input int n);
        logic [15:0] s;
        s = SEED;
        for (int i = 0; i < n; i++) s = lfsr_step(s);
        return DATA_W'($signed(s[FRAC_W-1:0]));
    endfunction

    logic [15:0] r_lfsr;
`endif

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                    r_state;
    logic [c_CW-1:0]           r_cnt;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [DATA_W-1:0]  r_w [N_INPUTS];
    logic signed [DATA_W-1:0]  r_bias;
    logic signed [DATA_W-1:0]  r_x [N_INPUTS];
    logic signed [DATA_W-1:0]  r_nw [N_OUTPUTS];
    logic signed [DATA_W-1:0]  r_ng [N_OUTPUTS];
    logic [1:0]                r_act;
    logic                      r_train;
    logic [3:0]                r_lr;
    logic signed [DATA_W-1:0]  r_d;
    logic signed [DATA_W-1:0]  r_pred;
    logic signed [DATA_W-1:0]  r_err;
    logic                      r_in_ready;
    logic                      r_out_valid;

    // ------------------------------------------------------------------------
    // Shared MAC operand select: counter indexes inputs in MAC/UPDATE and the
    // downstream pairs in GRAD.
    // ------------------------------------------------------------------------
    logic signed [DATA_W-1:0]  w_xk, w_wk, w_nwk, w_ngk, w_op_a, w_op_b;

    always_comb begin
        w_xk  = '0;
        w_wk  = '0;
        w_nwk = '0;
        w_ngk = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (r_cnt == c_CW'(k)) begin
                w_xk = r_x[k];
                w_wk = r_w[k];
            end
        end
        for (int j = 0; j < N_OUTPUTS; j++) begin
            if (r_cnt == c_CW'(j)) begin
                w_nwk = r_nw[j];
                w_ngk = r_ng[j];
            end
        end
        w_op_a = (r_state == S_GRAD) ? w_nwk : w_wk;
        w_op_b = (r_state == S_GRAD) ? w_ngk : w_xk;
    end

    logic signed [c_PW-1:0]    w_prod;
    logic signed [ACC_W-1:0]   w_acc_next;

    assign w_prod     = c_PW'(w_op_a) * c_PW'(w_op_b);
    assign w_acc_next = r_acc + ACC_W'(w_prod);

    // ------------------------------------------------------------------------
    // Activation and derivative from the saturated forward sum
    // ------------------------------------------------------------------------
    logic signed [DATA_W-1:0]  w_sum, w_act, w_deriv;
    logic signed [c_AW-1:0]    w_s2, w_hs;

    assign w_sum = sat(c_WIDE'(r_acc >>> FRAC_W));
    assign w_s2  = c_AW'(w_sum);

    always_comb begin
        w_act   = w_sum;
        w_deriv = c_ONE;
        w_hs    = (w_s2 >>> 2) + c_HALF_A;
        case (r_act)
            2'd1: begin
                w_act   = (w_sum < 0) ? '0 : w_sum;
                w_deriv = (w_sum < 0) ? '0 : c_ONE;
            end
            2'd2: begin
                if (w_hs < 0)            w_act = '0;
                else if (w_hs > c_ONE_A) w_act = c_ONE;
                else                     w_act = w_hs[DATA_W-1:0];
                w_deriv = ((w_s2 > -c_TWO_A) && (w_s2 < c_TWO_A)) ? c_QUART : '0;
            end
            2'd3: begin
                if (w_s2 < -c_ONE_A)     w_act = -c_ONE;
                else if (w_s2 > c_ONE_A) w_act = c_ONE;
                else                     w_act = w_sum;
                w_deriv = ((w_s2 >= -c_ONE_A) && (w_s2 <= c_ONE_A)) ? c_ONE : '0;
            end
            default: begin
                w_act   = w_sum;
                w_deriv = c_ONE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Local delta (evaluated on the last GRAD cycle, including its product)
    // and the weight / bias update values.
    // ------------------------------------------------------------------------
    logic signed [c_WIDE-1:0]  w_gmul;
    logic signed [DATA_W-1:0]  w_err;
    logic signed [c_PW-1:0]    w_ex, w_dw;
    logic signed [DATA_W-1:0]  w_wnew, w_bnew;

    assign w_gmul = c_WIDE'(w_acc_next >>> FRAC_W) * c_WIDE'(r_d);
    assign w_err  = sat(w_gmul >>> FRAC_W);
    assign w_ex   = c_PW'(r_err) * c_PW'(w_xk);
    assign w_dw   = (w_ex >>> FRAC_W) >>> r_lr;
    assign w_wnew = sat(c_WIDE'(w_wk) - c_WIDE'(w_dw));
    assign w_bnew = sat(c_WIDE'(r_bias) - c_WIDE'(r_err >>> r_lr));

    // ------------------------------------------------------------------------
    // Control and datapath state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_act       <= '0;
            r_train     <= 1'b0;
            r_lr        <= '0;
            r_d         <= '0;
            r_pred      <= '0;
            r_err       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            for (int k = 0; k < N_INPUTS; k++) begin
                r_x[k] <= '0;
`ifdef FXP_NEURON_LFSR_INIT_EN
                r_w[k] <= lfsr_word(k + 1);
`else
                r_w[k] <= '0;
`endif
            end
            for (int j = 0; j < N_OUTPUTS; j++) begin
                r_nw[j] <= '0;
                r_ng[j] <= '0;
            end
`ifdef FXP_NEURON_LFSR_INIT_EN
            r_bias <= lfsr_word(N_INPUTS + 1);
            r_lfsr <= SEED;
`else
            r_bias <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        for (int k = 0; k < N_INPUTS; k++)
                            r_x[k] <= in_values[k*DATA_W +: DATA_W];
                        for (int j = 0; j < N_OUTPUTS; j++) begin
                            r_nw[j] <= next_weights[j*DATA_W +: DATA_W];
                            r_ng[j] <= next_grads[j*DATA_W +: DATA_W];
                        end
                        r_act      <= activation;
                        r_train    <= train;
                        r_lr       <= lr_shift;
                        r_acc      <= ACC_W'(r_bias) <<< FRAC_W;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_MAC;
`ifdef FXP_NEURON_LFSR_INIT_EN
                        r_lfsr     <= lfsr_step(r_lfsr);
`endif
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    if (r_cnt == c_CW'(N_INPUTS - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_ACT;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                S_ACT: begin
                    r_pred <= w_act;
                    r_d    <= w_deriv;
                    r_acc  <= '0;
                    if (r_train) begin
                        r_state <= S_GRAD;
                    end else begin
                        r_err       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_GRAD: begin
                    r_acc <= w_acc_next;
                    if (r_cnt == c_CW'(N_OUTPUTS - 1)) begin
                        r_err   <= w_err;
                        r_cnt   <= '0;
                        r_state <= S_UPDATE;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                S_UPDATE: begin
                    if (r_cnt == c_CW'(N_INPUTS)) begin
                        r_bias      <= w_bnew;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        for (int k = 0; k < N_INPUTS; k++)
                            if (r_cnt == c_CW'(k)) r_w[k] <= w_wnew;
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready       = r_in_ready;
    assign out_valid      = r_out_valid;
    assign prediction     = r_pred;
    assign error_gradient = r_err;

    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_pack_w
        assign weights_out[gi*DATA_W +: DATA_W] = r_w[gi];
    end
    assign weights_out[N_INPUTS*DATA_W +: DATA_W] = r_bias;

endmodule
`default_nettype wire

// File: tb/tb_fxp_seq_neuron.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fxp_seq_neuron
//  Purpose  : Self-checking bench for fxp_seq_neuron (default parameters,
//             LFSR init disabled). Directed scenarios plus randomized
//             requests compared against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fxp_seq_neuron;

    localparam int N  = 4;
    localparam int NO = 2;
    localparam int DW = 16;
    localparam int FW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [N*DW-1:0]      in_values;
    logic [1:0]           activation;
    logic                 train;
    logic [3:0]           lr_shift;
    logic [NO*DW-1:0]     next_weights;
    logic [NO*DW-1:0]     next_grads;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        prediction;
    logic [DW-1:0]        error_gradient;
    logic [(N+1)*DW-1:0]  weights_out;

    fxp_seq_neuron #(
        .N_INPUTS (N),
        .N_OUTPUTS(NO),
        .DATA_W   (DW),
        .FRAC_W   (FW),
        .ACC_W    (40),
        .SEED     (16'hACE1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_values     (in_values),
        .activation    (activation),
        .train         (train),
        .lr_shift      (lr_shift),
        .next_weights  (next_weights),
        .next_grads    (next_grads),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .prediction    (prediction),
        .error_gradient(error_gradient),
        .weights_out   (weights_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus vectors and reference model state (index N = bias)
    int     x_v [N];
    int     nw_v[NO];
    int     ng_v[NO];
    longint mw  [N+1];
    longint exp_pred, exp_err;
    int     lat;
    logic signed [DW-1:0] got_pred, got_err;

    function automatic longint msat(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint wout(input int i);
        logic signed [DW-1:0] t;
        t = weights_out[i*DW +: DW];
        return longint'(t);
    endfunction

    // Reference: forward sum, activation, delta, and update from the rules
    task automatic model_run(input int act, input bit tr, input int lr);
        longint acc, s, p, d, g, e;
        acc = mw[N] * 256;
        for (int k = 0; k < N; k++) acc += mw[k] * x_v[k];
        s = msat(acc >>> FW);
        case (act)
            0: begin p = s; d = 256; end
            1: begin p = (s < 0) ? 0 : s; d = (s >= 0) ? 256 : 0; end
            2: begin
                p = (s >>> 2) + 128;
                if (p < 0) p = 0;
                if (p > 256) p = 256;
                d = (s > -512 && s < 512) ? 64 : 0;
            end
            default: begin
                p = s;
                if (p < -256) p = -256;
                if (p > 256) p = 256;
                d = (s >= -256 && s <= 256) ? 256 : 0;
            end
        endcase
        e = 0;
        if (tr) begin
            g = 0;
            for (int j = 0; j < NO; j++) g += longint'(nw_v[j]) * ng_v[j];
            e = msat(((g >>> FW) * d) >>> FW);
            for (int k = 0; k < N; k++)
                mw[k] = msat(mw[k] - (((e * x_v[k]) >>> FW) >>> lr));
            mw[N] = msat(mw[N] - (e >>> lr));
        end
        exp_pred = p;
        exp_err  = e;
    endtask

    // Issue one request (in_ready assumed high), wait for out_valid
    task automatic issue(input int act, input bit tr, input int lr);
        @(negedge clk);
        for (int k = 0; k < N; k++)  in_values[k*DW +: DW]    = DW'(x_v[k]);
        for (int j = 0; j < NO; j++) next_weights[j*DW +: DW] = DW'(nw_v[j]);
        for (int j = 0; j < NO; j++) next_grads[j*DW +: DW]   = DW'(ng_v[j]);
        activation = 2'(act);
        train      = tr;
        lr_shift   = 4'(lr);
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        got_pred = prediction;
        got_err  = error_gradient;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic set_x(input int a, input int b, input int c, input int d);
        x_v[0] = a; x_v[1] = b; x_v[2] = c; x_v[3] = d;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i <= N; i++) mw[i] = 0;
    endtask

    task automatic test_reset();
        in_valid = 0; out_ready = 0; activation = 0; train = 0; lr_shift = 0;
        in_values = '0; next_weights = '0; next_grads = '0;
        apply_reset();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (prediction !== '0) begin n_fail++; $display("FAIL reset_pred got %0d want 0", $signed(prediction)); end
        n_checks++; if (error_gradient !== '0) begin n_fail++; $display("FAIL reset_err got %0d want 0", $signed(error_gradient)); end
        n_checks++; if (weights_out !== '0) begin n_fail++; $display("FAIL reset_weights got %h want 0", weights_out); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_inference();
        set_x(256, 256, 256, 256);
        nw_v[0] = 0; nw_v[1] = 0; ng_v[0] = 0; ng_v[1] = 0;
        model_run(0, 0, 0);
        issue(0, 0, 0);
        n_checks++; if (lat != 5) begin n_fail++; $display("FAIL infer_latency got %0d want 5", lat); end
        n_checks++; if (got_pred !== 16'sd0) begin n_fail++; $display("FAIL infer_pred got %0d want 0", got_pred); end
        n_checks++; if (got_err !== 16'sd0) begin n_fail++; $display("FAIL infer_err got %0d want 0", got_err); end
        release_out();
    endtask

    task automatic test_training();
        logic signed [DW-1:0] want [N+1];
        set_x(256, 512, 0, 0);
        nw_v[0] = 256; nw_v[1] = 0; ng_v[0] = -256; ng_v[1] = 0;
        model_run(0, 1, 0);
        issue(0, 1, 0);
        want[0] = 256; want[1] = 512; want[2] = 0; want[3] = 0; want[4] = 256;
        n_checks++; if (lat != 12) begin n_fail++; $display("FAIL train_latency got %0d want 12", lat); end
        n_checks++; if (got_err !== -16'sd256) begin n_fail++; $display("FAIL train_err got %0d want -256", got_err); end
        for (int i = 0; i <= N; i++) begin
            n_checks++;
            if (wout(i) != longint'(want[i])) begin
                n_fail++; $display("FAIL train_w%0d got %0d want %0d", i, wout(i), want[i]);
            end
        end
        release_out();
        // infer again on the same inputs with the trained weights
        model_run(0, 0, 0);
        issue(0, 0, 0);
        n_checks++; if (got_pred !== 16'sd1536) begin n_fail++; $display("FAIL retrain_pred got %0d want 1536", got_pred); end
        release_out();
    endtask

    task automatic test_activations();
        set_x(-1024, 0, 0, 0);
        nw_v[0] = int'($urandom_range(0, 1023)) - 512; nw_v[1] = int'($urandom_range(0, 1023)) - 512;
        ng_v[0] = int'($urandom_range(0, 1023)) - 512; ng_v[1] = int'($urandom_range(0, 1023)) - 512;
        model_run(1, 1, 2);
        issue(1, 1, 2);
        n_checks++; if (got_pred !== 16'sd0) begin n_fail++; $display("FAIL relu_pred got %0d want 0", got_pred); end
        n_checks++; if (got_err !== 16'sd0) begin n_fail++; $display("FAIL relu_err got %0d want 0", got_err); end
        n_checks++;
        if (wout(0) != 256 || wout(1) != 512 || wout(2) != 0 || wout(3) != 0 || wout(4) != 256) begin
            n_fail++; $display("FAIL relu_weights got %h want unchanged", weights_out);
        end
        release_out();
        model_run(2, 0, 0);
        issue(2, 0, 0);
        n_checks++; if (got_pred !== 16'sd0) begin n_fail++; $display("FAIL hsig_neg_pred got %0d want 0", got_pred); end
        release_out();
        set_x(0, 0, 0, 0);
        model_run(2, 0, 0);
        issue(2, 0, 0);
        n_checks++; if (got_pred !== 16'sd192) begin n_fail++; $display("FAIL hsig_zero_pred got %0d want 192", got_pred); end
        release_out();
        set_x(256, 0, 0, 0);        // sum = 512, clamps to 1.0
        model_run(3, 0, 0);
        issue(3, 0, 0);
        n_checks++; if (got_pred !== 16'sd256) begin n_fail++; $display("FAIL htanh_pred got %0d want 256", got_pred); end
        release_out();
    endtask

    task automatic test_backpressure();
        logic signed [DW-1:0] held;
        set_x(100, -50, 25, 300);
        model_run(3, 0, 0);
        issue(3, 0, 0);
        held = got_pred;
        n_checks++; if (longint'(got_pred) != exp_pred) begin n_fail++; $display("FAIL bp_pred got %0d want %0d", got_pred, exp_pred); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            n_checks++;
            if (prediction !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d pred %0d ov %b ir %b want %0d 1 0", i, $signed(prediction), out_valid, in_ready, held);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release ir %b ov %b want 1 0", in_ready, out_valid); end
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_not_queued ov %b ir %b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid();
        set_x(300, 200, -100, 50);
        nw_v[0] = 256; nw_v[1] = 128; ng_v[0] = 100; ng_v[1] = -300;
        @(negedge clk);
        for (int k = 0; k < N; k++)  in_values[k*DW +: DW]    = DW'(x_v[k]);
        for (int j = 0; j < NO; j++) next_weights[j*DW +: DW] = DW'(nw_v[j]);
        for (int j = 0; j < NO; j++) next_grads[j*DW +: DW]   = DW'(ng_v[j]);
        activation = 0; train = 1; lr_shift = 0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        n_checks++; if (weights_out !== '0) begin n_fail++; $display("FAIL midrst_weights got %h want 0", weights_out); end
        for (int i = 0; i <= N; i++) mw[i] = 0;
        @(negedge clk); rst = 1'b0;
        model_run(0, 1, 1);
        issue(0, 1, 1);
        n_checks++; if (lat != 12) begin n_fail++; $display("FAIL midrst_latency got %0d want 12", lat); end
        n_checks++; if (longint'(got_err) != exp_err) begin n_fail++; $display("FAIL midrst_err got %0d want %0d", got_err, exp_err); end
        for (int i = 0; i <= N; i++) begin
            n_checks++;
            if (wout(i) != mw[i]) begin n_fail++; $display("FAIL midrst_w%0d got %0d want %0d", i, wout(i), mw[i]); end
        end
        release_out();
    endtask

    task automatic test_random();
        int act, lr;
        bit tr;
        for (int it = 0; it < 24; it++) begin
            for (int k = 0; k < N; k++) x_v[k] = int'($urandom_range(0, 2047)) - 1024;
            for (int j = 0; j < NO; j++) begin
                nw_v[j] = int'($urandom_range(0, 2047)) - 1024;
                ng_v[j] = int'($urandom_range(0, 2047)) - 1024;
            end
            act = int'($urandom_range(0, 3));
            tr  = 1'($urandom_range(0, 1));
            lr  = int'($urandom_range(0, 7));
            model_run(act, tr, lr);
            issue(act, tr, lr);
            n_checks++;
            if (lat != (tr ? 12 : 5)) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", it, lat, tr ? 12 : 5); end
            n_checks++;
            if (longint'(got_pred) != exp_pred) begin n_fail++; $display("FAIL rnd%0d_pred got %0d want %0d", it, got_pred, exp_pred); end
            n_checks++;
            if (longint'(got_err) != exp_err) begin n_fail++; $display("FAIL rnd%0d_err got %0d want %0d", it, got_err, exp_err); end
            for (int i = 0; i <= N; i++) begin
                n_checks++;
                if (wout(i) != mw[i]) begin n_fail++; $display("FAIL rnd%0d_w%0d got %0d want %0d", it, i, wout(i), mw[i]); end
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_inference();
        test_training();
        test_activations();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
